// File: rtl/vram_arbiter_pkg.sv
// Shared VRAM port constants, client indices and read-return tag type for the VRAM arbiter.
package vram_arbiter_pkg;

  localparam int unsigned VRAM_ADDR_WIDTH    = 16;
  localparam int unsigned VRAM_DATA_WIDTH    = 16;
  localparam int unsigned VRAM_MAX_CLIENTS   = 8;
  localparam int unsigned VRAM_MAX_CID_WIDTH = 3;

  localparam int unsigned VRAM_CLIENT_MPU    = 0;
  localparam int unsigned VRAM_CLIENT_TILE   = 1;
  localparam int unsigned VRAM_CLIENT_SPRITE = 2;
  localparam int unsigned VRAM_CLIENT_BG     = 3;

  typedef enum logic {
    ARB_ROUND_ROBIN    = 1'b0,
    ARB_FIXED_PRIORITY = 1'b1
  } arb_mode_e;

  // One slot of the read-return shift register.
  typedef struct packed {
    logic                          valid;
    logic [VRAM_MAX_CID_WIDTH-1:0] cid;
  } rd_tag_t;

  // Client-id width; never narrower than one bit.
  function automatic int unsigned cid_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vram_arbiter_arb.sv
// Combinational round-robin / fixed-priority arbiter with its rotating pointer register.
module rr_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS    = 4,
  parameter int unsigned FIXED_PRIORITY = 0,
  localparam int unsigned CIDW          = cid_width(NUM_CLIENTS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CLIENTS-1:0] i_req,
  output logic [NUM_CLIENTS-1:0] o_grant_c,
  output logic [CIDW-1:0]        o_idx_c,
  output logic                   o_valid_c
);

  localparam arb_mode_e MODE = (FIXED_PRIORITY != 0) ? ARB_FIXED_PRIORITY : ARB_ROUND_ROBIN;

  logic [CIDW-1:0] r_ptr;
  logic [CIDW-1:0] w_cand;

  // Candidate k of the search: ptr+1+k wrapped modulo NUM_CLIENTS (not a power of two).
  function automatic logic [CIDW-1:0] rr_index(input logic [CIDW-1:0] ptr, input int unsigned k);
    int unsigned s;
    s = 32'(ptr) + 32'd1 + k;
    if (s >= NUM_CLIENTS) s = s - NUM_CLIENTS;
    return CIDW'(s);
  endfunction

  // First eligible candidate in search order wins.
  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    w_cand    = '0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      w_cand = (MODE == ARB_FIXED_PRIORITY) ? CIDW'(k) : rr_index(r_ptr, k);
      if (!o_valid_c && i_req[w_cand]) begin
        o_valid_c         = 1'b1;
        o_idx_c           = w_cand;
        o_grant_c[w_cand] = 1'b1;
      end
    end
  end

  // Pointer parks on the last winner; reset value makes client 0 first in line.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= CIDW'(NUM_CLIENTS - 1);
    end else if (o_valid_c && (MODE == ARB_ROUND_ROBIN)) begin
      r_ptr <= o_idx_c;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// N-client VRAM port arbiter: grant, registered issue stage and tagged read-return pipeline.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS    = 4,
  parameter int unsigned ADDR_WIDTH     = VRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = VRAM_DATA_WIDTH,
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  mpu_lock,
  input  logic [NUM_CLIENTS-1:0]                req,
  input  logic [NUM_CLIENTS-1:0]                wr,
  input  logic [NUM_CLIENTS*(DATA_WIDTH/8)-1:0] be,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]     addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0]     wdata,
  output logic [NUM_CLIENTS-1:0]                grant,
  output logic [NUM_CLIENTS-1:0]                rd_valid,
  output logic [DATA_WIDTH-1:0]                 rd_data,
  output logic                                  vram_en,
  output logic                                  vram_rd,
  output logic                                  vram_wr,
  output logic [DATA_WIDTH/8-1:0]               vram_be,
  output logic [ADDR_WIDTH-1:0]                 vram_addr,
  output logic [DATA_WIDTH-1:0]                 vram_data_out,
  input  logic [DATA_WIDTH-1:0]                 vram_data_in
);

  localparam int unsigned BEW  = DATA_WIDTH / 8;
  localparam int unsigned CIDW = cid_width(NUM_CLIENTS);

  logic [NUM_CLIENTS-1:0] w_lock_mask;
  logic [NUM_CLIENTS-1:0] w_elig;
  logic [NUM_CLIENTS-1:0] w_grant;
  logic [CIDW-1:0]        w_idx;
  logic                   w_any;

  logic                   w_sel_wr;
  logic [BEW-1:0]         w_sel_be;
  logic [ADDR_WIDTH-1:0]  w_sel_addr;
  logic [DATA_WIDTH-1:0]  w_sel_wdata;

  logic                   r_vram_en;
  logic                   r_vram_rd;
  logic                   r_vram_wr;
  logic [BEW-1:0]         r_vram_be;
  logic [ADDR_WIDTH-1:0]  r_vram_addr;
  logic [DATA_WIDTH-1:0]  r_vram_data_out;
  logic [CIDW-1:0]        r_iss_cid;

  rd_tag_t                r_pipe [READ_LATENCY];
  rd_tag_t                w_ret;
  logic [NUM_CLIENTS-1:0] r_rd_valid;
  logic [DATA_WIDTH-1:0]  r_rd_data;

  // Lock narrows eligibility to the MPU; reset suppresses any grant in its own cycle.
  assign w_lock_mask = mpu_lock ? (NUM_CLIENTS'(1) << VRAM_CLIENT_MPU) : '1;
  assign w_elig      = reset ? '0 : (req & w_lock_mask);

  rr_arbiter #(
    .NUM_CLIENTS   (NUM_CLIENTS),
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_req    (w_elig),
    .o_grant_c(w_grant),
    .o_idx_c  (w_idx),
    .o_valid_c(w_any)
  );

  assign grant = w_grant;

  // Winner's request fields.
  always_comb begin
    w_sel_wr    = wr[w_idx];
    w_sel_be    = be[w_idx*BEW +: BEW];
    w_sel_addr  = addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
    w_sel_wdata = wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  // Issue register; address and write data hold across idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vram_en       <= 1'b0;
      r_vram_rd       <= 1'b0;
      r_vram_wr       <= 1'b0;
      r_vram_be       <= '0;
      r_vram_addr     <= '0;
      r_vram_data_out <= '0;
      r_iss_cid       <= '0;
    end else if (w_any) begin
      r_vram_en       <= 1'b1;
      r_vram_rd       <= ~w_sel_wr;
      r_vram_wr       <= w_sel_wr;
      r_vram_be       <= w_sel_be;
      r_vram_addr     <= w_sel_addr;
      r_vram_data_out <= w_sel_wdata;
      r_iss_cid       <= w_idx;
    end else begin
      r_vram_en       <= 1'b0;
      r_vram_rd       <= 1'b0;
      r_vram_wr       <= 1'b0;
      r_vram_be       <= '0;
    end
  end

  assign vram_en       = r_vram_en;
  assign vram_rd       = r_vram_rd;
  assign vram_wr       = r_vram_wr;
  assign vram_be       = r_vram_be;
  assign vram_addr     = r_vram_addr;
  assign vram_data_out = r_vram_data_out;

  // Tag shift register: the last stage lines up with valid vram_data_in.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= '{valid: r_vram_rd, cid: VRAM_MAX_CID_WIDTH'(r_iss_cid)};
      for (int i = 1; i < READ_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_ret = r_pipe[READ_LATENCY-1];

  // Registered return; rd_data holds between returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= '0;
      r_rd_data  <= '0;
    end else if (w_ret.valid) begin
      r_rd_valid <= NUM_CLIENTS'(1) << w_ret.cid;
      r_rd_data  <= vram_data_in;
    end else begin
      r_rd_valid <= '0;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: reference model predicts grants, port activity and read returns.
module tb_vram_arbiter;

  localparam int N   = 4;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int RL  = 2;
  localparam int BEW = DW / 8;

  typedef struct {
    bit             en;
    bit             wr;
    logic [BEW-1:0] be;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
  } port_t;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } ret_t;

  typedef struct {
    bit            v;
    logic [DW-1:0] d;
  } dev_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             lock = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     wr = '0;
  logic [N*BEW-1:0] be = '0;
  logic [N*AW-1:0]  addr = '0;
  logic [N*DW-1:0]  wdata = '0;
  logic [N-1:0]     grant, rd_valid;
  logic [DW-1:0]    rd_data;
  logic             vram_en, vram_rd, vram_wr;
  logic [BEW-1:0]   vram_be;
  logic [AW-1:0]    vram_addr;
  logic [DW-1:0]    vram_data_out;
  logic [DW-1:0]    vram_data_in = '0;

  logic [N-1:0]     grant_fp, rd_valid_fp;
  logic [DW-1:0]    rd_data_fp, vram_data_out_fp;
  logic             vram_en_fp, vram_rd_fp, vram_wr_fp;
  logic [BEW-1:0]   vram_be_fp;
  logic [AW-1:0]    vram_addr_fp;
  logic [DW-1:0]    vram_data_in_fp = '0;

  vram_arbiter #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                 .READ_LATENCY(RL), .FIXED_PRIORITY(0)) u_dut (
    .clk(clk), .reset(rst), .mpu_lock(lock), .req(req), .wr(wr), .be(be),
    .addr(addr), .wdata(wdata), .grant(grant), .rd_valid(rd_valid), .rd_data(rd_data),
    .vram_en(vram_en), .vram_rd(vram_rd), .vram_wr(vram_wr), .vram_be(vram_be),
    .vram_addr(vram_addr), .vram_data_out(vram_data_out), .vram_data_in(vram_data_in));

  vram_arbiter #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                 .READ_LATENCY(RL), .FIXED_PRIORITY(1)) u_dut_fp (
    .clk(clk), .reset(rst), .mpu_lock(lock), .req(req), .wr(wr), .be(be),
    .addr(addr), .wdata(wdata), .grant(grant_fp), .rd_valid(rd_valid_fp), .rd_data(rd_data_fp),
    .vram_en(vram_en_fp), .vram_rd(vram_rd_fp), .vram_wr(vram_wr_fp), .vram_be(vram_be_fp),
    .vram_addr(vram_addr_fp), .vram_data_out(vram_data_out_fp), .vram_data_in(vram_data_in_fp));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  port_t q_port[$];
  ret_t  q_ret[$];

  logic [DW-1:0] refmem [0:65535];
  logic [DW-1:0] devmem [0:65535];
  dev_t          dpipe [RL+1];
  int            ptr = N - 1;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;

  logic             s_rst = 1'b1, s_lock = 1'b0;
  logic [N-1:0]     s_req = '0, s_wr = '0;
  logic [N*BEW-1:0] s_be = '0;
  logic [N*AW-1:0]  s_addr = '0;
  logic [N*DW-1:0]  s_wdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  task automatic set_client(input int c, input bit r, input bit w, input logic [BEW-1:0] b,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    s_req[c]              = r;
    s_wr[c]               = w;
    s_be[c*BEW +: BEW]    = b;
    s_addr[c*AW +: AW]    = a;
    s_wdata[c*DW +: DW]   = d;
  endtask

  // Apply staged inputs for one cycle and predict everything that follows from them.
  task automatic step();
    port_t        p;
    ret_t         r;
    logic [N-1:0] elig;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BEW-1:0] b;
    int           win, win_fp, j;
    @(negedge clk);
    rst = s_rst; lock = s_lock; req = s_req; wr = s_wr; be = s_be; addr = s_addr; wdata = s_wdata;
    mon_en = 1'b1;
    #1;
    elig = s_rst ? '0 : (s_lock ? (s_req & N'(1)) : s_req);
    win = -1; win_fp = -1;
    for (int k = 0; k < N; k++) if (elig[k] && win_fp < 0) win_fp = k;
    for (int k = 1; k <= N; k++) begin
      j = (ptr + k) % N;
      if (elig[j] && win < 0) win = j;
    end
    chk("grant_rr", grant, onehot(win));
    chk("grant_fp", grant_fp, onehot(win_fp));
    p.en = 0; p.wr = 0; p.be = '0;
    if (s_rst) begin
      ptr = N - 1; last_addr = '0; last_data = '0;
      q_ret.delete();
    end else if (win >= 0) begin
      ptr = win;
      a = s_addr[win*AW +: AW]; d = s_wdata[win*DW +: DW]; b = s_be[win*BEW +: BEW];
      p.en = 1; p.wr = s_wr[win]; p.be = b;
      last_addr = a; last_data = d;
      if (s_wr[win]) begin
        for (int k = 0; k < BEW; k++) if (b[k]) refmem[a][k*8 +: 8] = d[k*8 +: 8];
      end else begin
        r.id = win; r.data = refmem[a]; r.due = cyc + RL + 2;
        q_ret.push_back(r);
      end
    end
    p.addr = last_addr; p.data = last_data;
    q_port.push_back(p);
  endtask

  // VRAM device: fixed read latency, byte-masked writes, garbage on non-read cycles.
  always @(negedge clk) begin
    for (int k = RL; k > 0; k--) dpipe[k] = dpipe[k-1];
    dpipe[0].v = vram_en && vram_rd;
    dpipe[0].d = devmem[vram_addr];
    if (vram_en && vram_wr)
      for (int k = 0; k < BEW; k++) if (vram_be[k]) devmem[vram_addr][k*8 +: 8] = vram_data_out[k*8 +: 8];
    vram_data_in = dpipe[RL].v ? dpipe[RL].d : DW'($urandom);
  end

  port_t m_p;
  ret_t  m_r;

  // Monitor: port activity each cycle, returns whenever rd_valid shows up or one is overdue.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (mon_en) begin
      if (q_port.size() > 0) begin
        m_p = q_port.pop_front();
        chk("vram_en", vram_en, m_p.en);
        chk("vram_rd", vram_rd, m_p.en && !m_p.wr);
        chk("vram_wr", vram_wr, m_p.en && m_p.wr);
        chk("vram_be", vram_be, m_p.be);
        chk("vram_addr", vram_addr, m_p.addr);
        chk("vram_data_out", vram_data_out, m_p.data);
      end
      if (rd_valid != '0) begin
        if (q_ret.size() == 0) begin
          chk("rd_valid_unexpected", rd_valid, '0);
        end else begin
          m_r = q_ret.pop_front();
          chk("rd_valid", rd_valid, onehot(m_r.id));
          chk("rd_data", rd_data, m_r.data);
          chk("rd_cycle", cyc, m_r.due);
        end
      end else if (q_ret.size() > 0 && q_ret[0].due <= cyc) begin
        m_r = q_ret.pop_front();
        chk("rd_valid_missing", rd_valid, onehot(m_r.id));
      end
    end
  end

  task automatic idle_stage();
    s_rst = 0; s_req = '0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      refmem[i] = DW'(i) ^ 16'hA5C3;
      devmem[i] = DW'(i) ^ 16'hA5C3;
    end
    refmem[16'h1234] = 16'hBEEF;
    devmem[16'h1234] = 16'hBEEF;
    for (int k = 0; k <= RL; k++) begin dpipe[k].v = 0; dpipe[k].d = '0; end

    // Reset for 2 cycles, then idle.
    s_rst = 1; s_req = '0;
    repeat (2) step();
    idle_stage();
    repeat (8) step();
    chk("rd_data_after_reset", rd_data, '0);

    // Single read from client 2.
    set_client(2, 1, 0, 2'b11, 16'h1234, 16'h0000);
    step();
    idle_stage();
    repeat (6) step();

    // Fairness: all four clients request for 8 cycles after a fresh reset.
    s_rst = 1; step(); s_rst = 0;
    for (int c = 0; c < N; c++) set_client(c, 1, 0, 2'b11, AW'(c * 4 + 1), '0);
    repeat (8) step();
    idle_stage();
    repeat (6) step();

    // MPU lock: renderer requests blocked, then the MPU write goes through.
    s_lock = 1;
    for (int c = 1; c < N; c++) set_client(c, 1, 0, 2'b11, AW'(c), '0);
    repeat (2) step();
    set_client(0, 1, 1, 2'b01, 16'h0010, 16'h00AA);
    step();
    idle_stage(); s_lock = 0;
    repeat (3) step();

    // Lock raised right after a client 3 read is granted.
    set_client(3, 1, 0, 2'b11, 16'h0010, '0);
    step();
    s_req = 4'b1110; s_lock = 1;
    repeat (5) step();
    s_lock = 0; idle_stage();
    step();

    // Reset one cycle after a client 1 read grant: no return, pointer restarts.
    idle_stage();
    set_client(1, 1, 0, 2'b11, 16'h1234, '0);
    step();
    s_req = '0; s_rst = 1;
    step();
    s_rst = 0;
    for (int c = 0; c < N; c++) set_client(c, 1, 0, 2'b11, AW'(c + 8), '0);
    step();
    idle_stage();
    repeat (6) step();

    // Random traffic with lock toggling, occasional reset and address reuse.
    for (int n = 0; n < 400; n++) begin
      s_rst  = ($urandom_range(0, 59) == 0);
      s_lock = ($urandom_range(0, 4) == 0);
      for (int c = 0; c < N; c++)
        set_client(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), BEW'($urandom),
                   ($urandom_range(0, 9) == 0) ? 16'h1234 : AW'($urandom_range(0, 31)), DW'($urandom));
      step();
    end

    idle_stage(); s_lock = 0;
    repeat (10) step();
    chk("returns_drained", 64'(q_ret.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Parametrised N-client arbiter and sequencer for the external VRAM port.
- Replaces the hard MPU/renderer mux, which is switched by the MEM_CTRL[0] bit, with cycle-by-cycle sharing among NUM_CLIENTS requesters.
- Client 0 is the MPU by convention; other clients are renderer fetch units. Arbitration is round-robin or fixed priority.
- Per-client grant handshake, pipelined read-return with client tagging, and an MPU lock mode.

Parameters:
- NUM_CLIENTS, 4: number of requesters (2..8).
- ADDR_WIDTH, 16: VRAM word address width.
- DATA_WIDTH, 16: VRAM data width (byte lanes = DATA_WIDTH/8).
- READ_LATENCY, 2: cycles from vram_rd issue to vram_data_in valid (1..4).
- FIXED_PRIORITY, 0: 0 = round-robin; 1 = lowest index wins.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- mpu_lock  in  1  when 1, only client 0 may be granted
- req  in  NUM_CLIENTS  per-client request, level
- wr  in  NUM_CLIENTS  per-client 1 = write, 0 = read
- be  in  NUM_CLIENTS*DATA_WIDTH/8  per-client byte enables, active-high
- addr  in  NUM_CLIENTS*ADDR_WIDTH  per-client address, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  in  NUM_CLIENTS*DATA_WIDTH  per-client write data
- grant  out  NUM_CLIENTS  one-hot; request accepted this cycle
- rd_valid  out  NUM_CLIENTS  one-hot; rd_data belongs to that client
- rd_data  out  DATA_WIDTH  returned read data
- vram_en  out  1  active-high access strobe
- vram_rd  out  1  active-high
- vram_wr  out  1  active-high
- vram_be  out  DATA_WIDTH/8  active-high
- vram_addr  out  ADDR_WIDTH
- vram_data_out  out  DATA_WIDTH
- vram_data_in  in  DATA_WIDTH

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - Outputs: vram_en/rd/wr/be = 0; vram_addr and vram_data_out = 0; grant = 0; rd_valid = 0; rd_data = 0.
  - Round-robin pointer = NUM_CLIENTS-1, so client 0 is searched first.
  - Read-return pipeline flushed. No rd_valid for any read issued before reset.
- Eligibility: eligible = req & (mpu_lock ? 1<<0 : all ones).
- Arbitration in cycle t is combinational on eligible.
  - grant is one-hot in cycle t for the winner; all zeros if nothing is eligible.
  - A client sees grant high in the same cycle as its accepted req. It may drop req or present the next request in cycle t+1.
  - Sustained req yields one access per grant.
- Round-robin: the search starts at pointer+1 mod NUM_CLIENTS. On any grant, pointer = winner index; the pointer holds when idle.
- Fixed priority: the lowest eligible index wins; the pointer is unused.
- Issue: the winner's wr/be/addr/wdata are registered and drive the VRAM port in cycle t+1.
  - vram_en = 1; vram_wr = wr; vram_rd = ~wr.
  - One access per cycle; back-to-back grants give fully pipelined issue with no bubble.
- Idle cycle: vram_en/rd/wr/be = 0; vram_addr and vram_data_out hold their last values.
- Read return:
  - Each issued read pushes {valid, client_id} into a READ_LATENCY-deep shift register.
  - vram_data_in is sampled READ_LATENCY cycles after the vram_rd cycle.
  - The registered rd_data and rd_valid[client_id] assert one cycle after that sample. Total grant-to-rd_valid = READ_LATENCY+2 cycles.
  - Writes push valid=0.
  - rd_valid is at most one-hot per cycle; returns come back in issue order.
- mpu_lock changes take effect in the same cycle's arbitration. Reads already in the pipeline still complete and return to their original clients.
- Width rules: client_id width is clog2(NUM_CLIENTS). Indices wrap modulo NUM_CLIENTS, not a power of two (e.g. 3 clients: 2 -> 0).
- Simultaneous reset and req: reset wins; no grant in that cycle.

Decomposition:
- Shared header vram_arbiter.vh: VRAM_ADDR_WIDTH, VRAM_DATA_WIDTH, client index constants (VRAM_CLIENT_MPU = 0, VRAM_CLIENT_TILE, VRAM_CLIENT_SPRITE, ...), and a clog2 function macro.
- One sub-module, rr_arbiter: req/pointer in, one-hot grant and encoded index out, with the FIXED_PRIORITY option. It is purely combinational plus the pointer register.
- The top level holds the issue register and the return pipeline.

Test Plan:
- Reset then idle:
  - Stimulus: req=0 for 10 cycles, reset held for 2 cycles then released.
  - Required: vram_en=0, grant=0, rd_valid=0 throughout.
- Single read:
  - Stimulus: client 2 reads addr 0x1234 with READ_LATENCY=2; model returns 0xBEEF.
  - Required: grant=0100 at t; vram_rd=1, vram_addr=0x1234 at t+1; rd_valid=0100, rd_data=0xBEEF at t+4.
- Round-robin fairness:
  - Stimulus: all 4 clients hold req for 8 cycles.
  - Required: grant sequence 0,1,2,3,0,1,2,3; then with FIXED_PRIORITY=1 grant stays at client 0 for all 8 cycles.
- MPU lock:
  - Stimulus: mpu_lock=1, req=1110.
  - Required: no grant. Then set req[0]=1 with wr=1, be=01, addr=0x0010, wdata=0x00AA.
  - Required response: vram_wr=1, vram_be=01, vram_data_out=0x00AA the next cycle.
- Lock mid-flight:
  - Stimulus: client 3 read granted, then mpu_lock=1 in the next cycle.
  - Required: client 3 still receives rd_valid at grant+4.
- Reset mid-read:
  - Stimulus: client 1 read granted, reset asserted one cycle later.
  - Required: no rd_valid ever for that read; pointer restarts so the first grant after reset goes to client 0.
